// File: rtl/ahb_arb_pkg.sv
// Shared constants and FSM state type for the two-master AHB-Lite arbiter.
// No ports; imported by ahb_arb_hold and ahb_arb_m2.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-port address-phase holding register with pending flag.
// Ports: clk/rst, upstream address-phase inputs, clear (owner completion),
//        pending flag and captured addr/size/prot/write/lock outputs.
module ahb_arb_hold
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        hsize,
    input  logic [3:0]        hprot,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic              hmastlock,
    input  logic              hready,
    input  logic              hselx,
    input  logic              clear,
    output logic              pending,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        size,
    output logic [3:0]        prot,
    output logic              write,
    output logic              lock
);

    logic active;
    logic capture;

    assign active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

    // The completion cycle frees the slot, so a new address presented
    // alongside it is taken immediately.
    assign capture = hselx & hready & active & (~pending | clear);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            addr    <= '0;
            size    <= '0;
            prot    <= '0;
            write   <= 1'b0;
            lock    <= 1'b0;
        end else if (capture) begin
            pending <= 1'b1;
            addr    <= haddr;
            size    <= hsize;
            prot    <= hprot;
            write   <= hwrite;
            lock    <= hmastlock;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_arb_m2.sv
// Two-master AHB-Lite arbiter: round-robin with HMASTLOCK hold, one transfer
// outstanding downstream. Ports: clk/rst, s0_*/s1_* upstream slave ports,
// m_* downstream master port. Define ARB_FIXED_PRIO_EN for fixed port-0 priority.
module ahb_arb_m2
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s0_haddr,
    input  logic [1:0]        s0_hsize,
    input  logic [2:0]        s0_hburst,
    input  logic [3:0]        s0_hprot,
    input  logic [1:0]        s0_htrans,
    input  logic              s0_hwrite,
    input  logic              s0_hmastlock,
    input  logic              s0_hready,
    input  logic              s0_hselx,
    input  logic [DATA_W-1:0] s0_hwdata,
    output logic [DATA_W-1:0] s0_hrdata,
    output logic              s0_hresp,
    output logic              s0_hreadyout,
    input  logic [ADDR_W-1:0] s1_haddr,
    input  logic [1:0]        s1_hsize,
    input  logic [2:0]        s1_hburst,
    input  logic [3:0]        s1_hprot,
    input  logic [1:0]        s1_htrans,
    input  logic              s1_hwrite,
    input  logic              s1_hmastlock,
    input  logic              s1_hready,
    input  logic              s1_hselx,
    input  logic [DATA_W-1:0] s1_hwdata,
    output logic [DATA_W-1:0] s1_hrdata,
    output logic              s1_hresp,
    output logic              s1_hreadyout,
    output logic [ADDR_W-1:0] m_haddr,
    output logic [1:0]        m_hsize,
    output logic [2:0]        m_hburst,
    output logic [3:0]        m_hprot,
    output logic [1:0]        m_htrans,
    output logic              m_hwrite,
    output logic              m_hlock,
    output logic [DATA_W-1:0] m_hwdata,
    input  logic [DATA_W-1:0] m_hrdata,
    input  logic              m_hresp,
    input  logic              m_hready
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              lock_q, lock_d;

    logic              pend0, pend1;
    logic [ADDR_W-1:0] a0, a1;
    logic [1:0]        sz0, sz1;
    logic [3:0]        pr0, pr1;
    logic              w0, w1, lk0, lk1;

    logic              done, elig0, elig1, pick;
    logic              in_data0, in_data1, own_lock;

    // Every transfer goes out as SINGLE, so upstream burst type is dropped.
    logic              unused_burst;
    assign unused_burst = ^{s0_hburst, s1_hburst};

    assign done     = (state_q == DATA) & m_hready;
    assign in_data0 = (state_q == DATA) & ~owner_q;
    assign in_data1 = (state_q == DATA) & owner_q;
    assign own_lock = owner_q ? lk1 : lk0;

    ahb_arb_hold #(.ADDR_W(ADDR_W)) u_hold0 (
        .clk(clk), .rst(rst),
        .haddr(s0_haddr), .hsize(s0_hsize), .hprot(s0_hprot),
        .htrans(s0_htrans), .hwrite(s0_hwrite), .hmastlock(s0_hmastlock),
        .hready(s0_hready), .hselx(s0_hselx), .clear(done & ~owner_q),
        .pending(pend0), .addr(a0), .size(sz0), .prot(pr0),
        .write(w0), .lock(lk0)
    );

    ahb_arb_hold #(.ADDR_W(ADDR_W)) u_hold1 (
        .clk(clk), .rst(rst),
        .haddr(s1_haddr), .hsize(s1_hsize), .hprot(s1_hprot),
        .htrans(s1_htrans), .hwrite(s1_hwrite), .hmastlock(s1_hmastlock),
        .hready(s1_hready), .hselx(s1_hselx), .clear(done & owner_q),
        .pending(pend1), .addr(a1), .size(sz1), .prot(pr1),
        .write(w1), .lock(lk1)
    );

    // A held lock leaves only the previous owner eligible.
    assign elig0 = pend0 & (~lock_q | ~last_q);
    assign elig1 = pend1 & (~lock_q | last_q);

`ifdef ARB_FIXED_PRIO_EN
    assign pick = ~elig0;
`else
    assign pick = (elig0 & elig1) ? ~last_q : elig1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        lock_d  = lock_q;
        unique case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    owner_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_hready) state_d = DATA;
            end
            DATA: begin
                if (m_hready) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    lock_d  = own_lock;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_haddr  = owner_q ? a1 : a0;
    assign m_hsize  = owner_q ? sz1 : sz0;
    assign m_hprot  = owner_q ? pr1 : pr0;
    assign m_hwrite = owner_q ? w1 : w0;
    assign m_hburst = HBURST_SINGLE;
    assign m_htrans = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign m_hlock  = (state_q == ADDR) & own_lock;
    assign m_hwdata = in_data0 ? s0_hwdata :
                      in_data1 ? s1_hwdata : '0;

    assign s0_hreadyout = in_data0 ? m_hready : ~pend0;
    assign s1_hreadyout = in_data1 ? m_hready : ~pend1;
    assign s0_hresp     = in_data0 & m_hresp;
    assign s1_hresp     = in_data1 & m_hresp;
    assign s0_hrdata    = m_hrdata;
    assign s1_hrdata    = m_hrdata;

endmodule

// File: tb/tb_ahb_arb_m2.sv
// Self-checking bench for ahb_arb_m2: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_ahb_arb_m2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] u_haddr[2];
    logic [1:0]  u_hsize[2];
    logic [2:0]  u_hburst[2];
    logic [3:0]  u_hprot[2];
    logic [1:0]  u_htrans[2];
    logic        u_hwrite[2], u_hlock[2], u_hready[2], u_hsel[2];
    logic [31:0] u_hwdata[2];
    logic [31:0] u_hrdata[2];
    logic        u_hresp[2], u_hreadyout[2];

    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic [1:0]  m_hsize, m_htrans;
    logic [2:0]  m_hburst;
    logic [3:0]  m_hprot;
    logic        m_hwrite, m_hlock, m_hresp, m_hready;

    ahb_arb_m2 dut (
        .clk(clk), .rst(rst),
        .s0_haddr(u_haddr[0]), .s0_hsize(u_hsize[0]), .s0_hburst(u_hburst[0]),
        .s0_hprot(u_hprot[0]), .s0_htrans(u_htrans[0]), .s0_hwrite(u_hwrite[0]),
        .s0_hmastlock(u_hlock[0]), .s0_hready(u_hready[0]), .s0_hselx(u_hsel[0]),
        .s0_hwdata(u_hwdata[0]), .s0_hrdata(u_hrdata[0]), .s0_hresp(u_hresp[0]),
        .s0_hreadyout(u_hreadyout[0]),
        .s1_haddr(u_haddr[1]), .s1_hsize(u_hsize[1]), .s1_hburst(u_hburst[1]),
        .s1_hprot(u_hprot[1]), .s1_htrans(u_htrans[1]), .s1_hwrite(u_hwrite[1]),
        .s1_hmastlock(u_hlock[1]), .s1_hready(u_hready[1]), .s1_hselx(u_hsel[1]),
        .s1_hwdata(u_hwdata[1]), .s1_hrdata(u_hrdata[1]), .s1_hresp(u_hresp[1]),
        .s1_hreadyout(u_hreadyout[1]),
        .m_haddr(m_haddr), .m_hsize(m_hsize), .m_hburst(m_hburst),
        .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hlock(m_hlock), .m_hwdata(m_hwdata), .m_hrdata(m_hrdata),
        .m_hresp(m_hresp), .m_hready(m_hready)
    );

    int checks = 0;
    int failures = 0;

    task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    // Reference model: queued request per port plus the transfer in flight.
    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [3:0]  pr;
        logic        w;
        logic        lk;
    } req_t;

    req_t rq[2];
    int   own = 0;
    int   ph = 0;      // 0 none in flight, 1 address issued, 2 data phase
    int   lastg = 1;
    bit   lkh = 0;
    bit   model_ok = 0;

    function automatic int pick();
        bit e0, e1;
        e0 = rq[0].v && (!lkh || lastg == 0);
        e1 = rq[1].v && (!lkh || lastg == 1);
        if (e0 && e1) begin
`ifdef ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - lastg;
`endif
        end
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic model_update();
        bit done;
        bit cap[2];
        int p;
        if (rst) begin
            rq[0].v = 1'b0;
            rq[1].v = 1'b0;
            ph = 0;
            own = 0;
            lastg = 1;
            lkh = 0;
            model_ok = 1;
            return;
        end
        if (!model_ok) return;
        done = (ph == 2) && m_hready;
        for (int i = 0; i < 2; i++)
            cap[i] = u_hsel[i] && u_hready[i] && u_htrans[i][1] &&
                     (!rq[i].v || (done && own == i));
        case (ph)
            0: begin
                p = pick();
                if (p >= 0) begin
                    own = p;
                    ph = 1;
                end
            end
            1: if (m_hready) ph = 2;
            default: if (m_hready) begin
                lastg = own;
                lkh = rq[own].lk;
                rq[own].v = 1'b0;
                ph = 0;
            end
        endcase
        for (int i = 0; i < 2; i++)
            if (cap[i]) begin
                rq[i].v  = 1'b1;
                rq[i].a  = u_haddr[i];
                rq[i].sz = u_hsize[i];
                rq[i].pr = u_hprot[i];
                rq[i].w  = u_hwrite[i];
                rq[i].lk = u_hlock[i];
            end
    endtask

    // Downstream slave responder and upstream completion recorder.
    bit          rnd = 0;
    bit          sl_dph = 0, sl_err = 0;
    logic [31:0] sl_addr = '0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    bit          outst[2];
    int          comp_port[$];
    logic [31:0] comp_data[$];
    logic        comp_resp[$];
    logic        errq[$];

    function automatic logic [31:0] data_for(input logic [31:0] a);
        case (a)
            32'h100: return 32'h1111_1111;
            32'h200: return 32'h2222_2222;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    task automatic drive_slave();
        m_hresp = 1'b0;
        m_hready = 1'b1;
        m_hrdata = $urandom;
        if (sl_dph) begin
            m_hrdata = rnd ? $urandom : data_for(sl_addr);
            if (sl_err) begin
                m_hresp = 1'b1;
            end else if (rnd ? ($urandom % 10 == 0) : (sl_addr == err_addr)) begin
                m_hresp = 1'b1;
                m_hready = 1'b0;
            end else if (rnd ? ($urandom % 4 == 0) : (sl_addr == stall_addr)) begin
                m_hready = 1'b0;
            end
        end else if (rnd) begin
            m_hready = ($urandom % 4) != 0;
        end
    endtask

    task automatic chk();
        bit ex_ro, ex_rs;
        #1;
        if (model_ok) begin
            cmp("m_htrans", 32'(m_htrans), (ph == 1) ? 32'd2 : 32'd0);
            cmp("m_hburst", 32'(m_hburst), 32'd0);
            if (ph == 1) begin
                cmp("m_haddr", m_haddr, rq[own].a);
                cmp("m_hsize", 32'(m_hsize), 32'(rq[own].sz));
                cmp("m_hprot", 32'(m_hprot), 32'(rq[own].pr));
                cmp("m_hwrite", 32'(m_hwrite), 32'(rq[own].w));
                cmp("m_hlock", 32'(m_hlock), 32'(rq[own].lk));
            end else begin
                cmp("m_hlock_idle", 32'(m_hlock), 32'd0);
            end
            if (ph == 2) cmp("m_hwdata", m_hwdata, u_hwdata[own]);
            for (int i = 0; i < 2; i++) begin
                ex_ro = (ph == 2 && own == i) ? m_hready : !rq[i].v;
                ex_rs = (ph == 2 && own == i) && m_hresp;
                cmp($sformatf("s%0d_hreadyout", i), 32'(u_hreadyout[i]), 32'(ex_ro));
                cmp($sformatf("s%0d_hresp", i), 32'(u_hresp[i]), 32'(ex_rs));
                cmp($sformatf("s%0d_hrdata", i), u_hrdata[i], m_hrdata);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) outst[i] = 0;
            else if (outst[i] && u_hreadyout[i]) begin
                comp_port.push_back(i);
                comp_data.push_back(u_hrdata[i]);
                comp_resp.push_back(u_hresp[i]);
                outst[i] = 0;
            end
        end
        if (!rst && u_hresp[0]) errq.push_back(u_hreadyout[0]);
        if (rst) begin
            sl_dph = 0;
            sl_err = 0;
        end else if (sl_dph) begin
            if (m_hready) begin
                sl_dph = 0;
                sl_err = 0;
            end else if (m_hresp) sl_err = 1;
        end else if (m_htrans == 2'b10 && m_hready) begin
            sl_dph = 1;
            sl_addr = m_haddr;
        end
    endtask

    task automatic pre();
        drive_slave();
        chk();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            pre();
            adv();
        end
    endtask

    task automatic idle_up();
        for (int i = 0; i < 2; i++) begin
            u_hsel[i] = 0; u_hready[i] = 1; u_htrans[i] = 2'b00;
            u_haddr[i] = '0; u_hsize[i] = 2'd2; u_hburst[i] = 3'd0;
            u_hprot[i] = 4'h3; u_hwrite[i] = 0; u_hlock[i] = 0;
            u_hwdata[i] = '0;
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic w,
                           input logic lk, input logic [31:0] wd);
        u_hsel[p] = 1; u_hready[p] = 1; u_htrans[p] = 2'b10;
        u_haddr[p] = a; u_hwrite[p] = w; u_hlock[p] = lk; u_hwdata[p] = wd;
    endtask

    task automatic clr_req(input int p);
        u_hsel[p] = 0;
        u_htrans[p] = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_up();
        run(2);
        rst = 0;
        comp_port.delete(); comp_data.delete(); comp_resp.delete(); errq.delete();
        outst[0] = 0; outst[1] = 0;
    endtask

    int nonseq;

    initial begin
        rst = 1;
        idle_up();
        @(negedge clk);
        do_reset();

        pre();
        cmp("rst_htrans", 32'(m_htrans), 32'd0);
        cmp("rst_haddr", m_haddr, 32'd0);
        cmp("rst_hlock", 32'(m_hlock), 32'd0);
        cmp("rst_ro0", 32'(u_hreadyout[0]), 32'd1);
        cmp("rst_ro1", 32'(u_hreadyout[1]), 32'd1);
        cmp("rst_resp0", 32'(u_hresp[0]), 32'd0);
        adv();

        // s0 write, zero-wait downstream
        set_req(0, 32'h2000_0010, 1, 0, 32'hA5A5_5A5A);
        pre(); cmp("t1_ro_cap", 32'(u_hreadyout[0]), 32'd1); adv();
        clr_req(0);
        pre(); cmp("t1_ro_w1", 32'(u_hreadyout[0]), 32'd0);
        cmp("t1_trans_w1", 32'(m_htrans), 32'd0); adv();
        pre(); cmp("t1_nonseq", 32'(m_htrans), 32'd2);
        cmp("t1_haddr", m_haddr, 32'h2000_0010);
        cmp("t1_hburst", 32'(m_hburst), 32'd0);
        cmp("t1_hwrite", 32'(m_hwrite), 32'd1);
        cmp("t1_ro_w2", 32'(u_hreadyout[0]), 32'd0); adv();
        pre(); cmp("t1_hwdata", m_hwdata, 32'hA5A5_5A5A);
        cmp("t1_ro_done", 32'(u_hreadyout[0]), 32'd1);
        cmp("t1_trans_d", 32'(m_htrans), 32'd0); adv();

        // simultaneous reads after reset
        do_reset();
        set_req(0, 32'h100, 0, 0, 0);
        set_req(1, 32'h200, 0, 0, 0);
        pre(); adv();
        clr_req(0); clr_req(1); outst[0] = 1; outst[1] = 1;
        run(12);
        cmp("t2_count", 32'(comp_port.size()), 32'd2);
        cmp("t2_first", 32'(comp_port[0]), 32'd0);
        cmp("t2_second", 32'(comp_port[1]), 32'd1);
        cmp("t2_data0", comp_data[0], 32'h1111_1111);
        cmp("t2_data1", comp_data[1], 32'h2222_2222);

        // lock hold
        do_reset();
        set_req(1, 32'h300, 0, 1, 0);
        pre(); adv();
        clr_req(1); outst[1] = 1;
        set_req(0, 32'h310, 0, 0, 0);
        pre(); adv();
        clr_req(0); outst[0] = 1;
        run(12);
        cmp("t3_held_count", 32'(comp_port.size()), 32'd1);
        cmp("t3_locked_first", 32'(comp_port[0]), 32'd1);
        pre(); cmp("t3_s0_stall", 32'(u_hreadyout[0]), 32'd0); adv();
        set_req(1, 32'h320, 1, 0, 32'hCAFE_F00D);
        pre(); adv();
        clr_req(1); outst[1] = 1;
        run(14);
        cmp("t3_count", 32'(comp_port.size()), 32'd3);
        cmp("t3_unlock", 32'(comp_port[1]), 32'd1);
        cmp("t3_s0_granted", 32'(comp_port[2]), 32'd0);

        // two-cycle error
        do_reset();
        err_addr = 32'h400;
        set_req(0, 32'h400, 0, 0, 0);
        pre(); adv();
        clr_req(0); outst[0] = 1;
        run(10);
        cmp("t4_err_len", 32'(errq.size()), 32'd2);
        cmp("t4_err_ro1", 32'(errq[0]), 32'd0);
        cmp("t4_err_ro2", 32'(errq[1]), 32'd1);
        cmp("t4_comp_resp", 32'(comp_resp[0]), 32'd1);
        pre(); cmp("t4_idle", 32'(m_htrans), 32'd0);
        cmp("t4_ro", 32'(u_hreadyout[0]), 32'd1); adv();
        err_addr = 32'hFFFF_FFFF;

        // reset during a stalled data phase
        do_reset();
        stall_addr = 32'h500;
        set_req(0, 32'h500, 0, 0, 0);
        pre(); adv();
        clr_req(0);
        run(2);
        rst = 1;
        pre(); cmp("t5_data_stall", 32'(u_hreadyout[0]), 32'd0); adv();
        rst = 0;
        stall_addr = 32'hFFFF_FFFF;
        pre(); cmp("t5_htrans", 32'(m_htrans), 32'd0);
        cmp("t5_ro0", 32'(u_hreadyout[0]), 32'd1);
        cmp("t5_ro1", 32'(u_hreadyout[1]), 32'd1); adv();
        nonseq = 0;
        for (int k = 0; k < 6; k++) begin
            pre();
            if (m_htrans == 2'b10) nonseq++;
            adv();
        end
        cmp("t5_no_reissue", 32'(nonseq), 32'd0);

        // randomized streaming traffic
        do_reset();
        rnd = 1;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 2; i++) begin
                u_hsel[i]   = ($urandom % 4) != 0;
                u_hready[i] = ($urandom % 8) != 0;
                u_htrans[i] = 2'($urandom_range(3));
                u_haddr[i]  = $urandom;
                u_hsize[i]  = 2'($urandom_range(3));
                u_hprot[i]  = 4'($urandom_range(15));
                u_hburst[i] = 3'($urandom_range(7));
                u_hwrite[i] = ($urandom % 2) != 0;
                u_hlock[i]  = ($urandom % 6) == 0;
                u_hwdata[i] = $urandom;
            end
            rst = ($urandom % 300) == 0;
            pre();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
